// File: rtl/cordic_angle_sequencer.sv
`timescale 1ns/1ps
// cordic_angle_sequencer
// Issues a sweep of angles (unsigned 12.20 degrees, wrapping at 360) with a
// fixed-amplitude vector to a downstream rotator of latency LAT, and tracks
// the rotator results through a LAT-deep {valid, index} delay line.
// Optional feature macro: CORDIC_SEQ_QUAD_TAG_EN adds result_quad, the
// quadrant of the issued angle, delayed alongside result_valid.
module cordic_angle_sequencer #(
  parameter int N   = 31,
  parameter int M   = 31,
  parameter int LAT = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M:0]   start_angle,
  input  logic [M:0]   step_angle,
  input  logic [15:0]  num_samples,
  input  logic [N:0]   amp,
  input  logic         hold,
  output logic [M:0]   angle_out,
  output logic [N:0]   x0_out,
  output logic [N:0]   y0_out,
  output logic         sample_valid,
  output logic         result_valid,
  output logic [15:0]  result_idx,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef CORDIC_SEQ_QUAD_TAG_EN
  ,
  output logic [1:0]   result_quad
`endif
);

  // Full turn in M+2 bits so that acc+step never overflows before reduction.
  localparam logic [M+1:0] ANG_360 = (M+2)'(32'h1680_0000);
  localparam logic [M:0]   ANG_360_S = (M+1)'(32'h1680_0000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [M:0]   acc_q, acc_d;
  logic [M:0]   step_q, step_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  num_q, num_d;
  logic         err_q, err_d;

  logic [M+1:0] sum;
  logic         cfg_ok;

  logic         dl_valid_q [LAT];
  logic         dl_valid_d [LAT];
  logic [15:0]  dl_idx_q   [LAT];
  logic [15:0]  dl_idx_d   [LAT];

`ifdef CORDIC_SEQ_QUAD_TAG_EN
  localparam logic [M:0] ANG_90  = (M+1)'(32'h05A0_0000);
  localparam logic [M:0] ANG_180 = (M+1)'(32'h0B40_0000);
  localparam logic [M:0] ANG_270 = (M+1)'(32'h10E0_0000);
  logic [1:0]   quad_now;
  logic [1:0]   dl_quad_q [LAT];
  logic [1:0]   dl_quad_d [LAT];
`endif

  // Next-state, sweep bookkeeping and issue-side outputs.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    num_d        = num_q;
    err_d        = 1'b0;
    sample_valid = 1'b0;
    done         = 1'b0;
    sum          = {1'b0, acc_q} + {1'b0, step_q};
    cfg_ok       = ({1'b0, start_angle} < ANG_360) && ({1'b0, step_angle} < ANG_360);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            acc_d   = start_angle;
            step_d  = step_angle;
            num_d   = num_samples;
            cnt_d   = 16'd0;
            state_d = (num_samples == 16'd0) ? S_DONE : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!hold) begin
          sample_valid = 1'b1;
          // Single conditional subtraction suffices: both operands are below 360.
          if (sum >= ANG_360) begin
            acc_d = acc_q + step_q - ANG_360_S;
          end else begin
            acc_d = acc_q + step_q;
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == num_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (result_valid && (result_idx == num_q - 16'd1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Delay-line input is the current issue; each stage shifts every cycle, hold or not.
  always_comb begin
    dl_valid_d[0] = sample_valid;
    dl_idx_d[0]   = sample_valid ? cnt_q : 16'd0;
    for (int i = 1; i < LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_idx_d[i]   = dl_idx_q[i-1];
    end
  end

`ifdef CORDIC_SEQ_QUAD_TAG_EN
  // Quadrant of the angle being issued, delayed in step with the index.
  always_comb begin
    if (acc_q < ANG_90) begin
      quad_now = 2'd0;
    end else if (acc_q < ANG_180) begin
      quad_now = 2'd1;
    end else if (acc_q < ANG_270) begin
      quad_now = 2'd2;
    end else begin
      quad_now = 2'd3;
    end
    dl_quad_d[0] = sample_valid ? quad_now : 2'd0;
    for (int i = 1; i < LAT; i++) begin
      dl_quad_d[i] = dl_quad_q[i-1];
    end
  end

  // Quadrant delay-line registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      if (rst) begin
        dl_quad_q[i] <= 2'd0;
      end else begin
        dl_quad_q[i] <= dl_quad_d[i];
      end
    end
  end

  assign result_quad = dl_quad_q[LAT-1];
`endif

  // State, configuration and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      cnt_q   <= 16'd0;
      num_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  // Valid/index delay-line registers; cleared by reset so no stale results survive.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      if (rst) begin
        dl_valid_q[i] <= 1'b0;
        dl_idx_q[i]   <= 16'd0;
      end else begin
        dl_valid_q[i] <= dl_valid_d[i];
        dl_idx_q[i]   <= dl_idx_d[i];
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign angle_out    = (state_q == S_RUN) ? acc_q : '0;
  assign x0_out       = sample_valid ? amp : '0;
  assign y0_out       = '0;
  assign result_valid = dl_valid_q[LAT-1];
  assign result_idx   = dl_idx_q[LAT-1];

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for cordic_angle_sequencer: directed and randomized
// sweeps compared against an arithmetic model of the angle sequence.
module tb_cordic_angle_sequencer;
  localparam int N = 31;
  localparam int M = 31;
  localparam int LAT = 18;
  localparam longint A360 = 64'h1680_0000;

  logic         clk = 1'b0;
  logic         rst, start, hold;
  logic [M:0]   start_angle, step_angle;
  logic [15:0]  num_samples;
  logic [N:0]   amp;
  logic [M:0]   angle_out;
  logic [N:0]   x0_out, y0_out;
  logic         sample_valid, result_valid, busy, done, err;
  logic [15:0]  result_idx;
`ifdef CORDIC_SEQ_QUAD_TAG_EN
  logic [1:0]   result_quad;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef struct {
    int     due;
    int     idx;
    longint ang;
  } res_t;

  always #5 clk = ~clk;

  cordic_angle_sequencer #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_angle(start_angle),
    .step_angle(step_angle), .num_samples(num_samples), .amp(amp), .hold(hold),
    .angle_out(angle_out), .x0_out(x0_out), .y0_out(y0_out),
    .sample_valid(sample_valid), .result_valid(result_valid),
    .result_idx(result_idx), .busy(busy), .done(done), .err(err)
`ifdef CORDIC_SEQ_QUAD_TAG_EN
    , .result_quad(result_quad)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint model_angle(input longint s, input longint st, input int k);
    return (s + longint'(k) * st) % A360;
  endfunction

  function automatic int model_quad(input longint a);
    if (a < 64'h05A0_0000) return 0;
    if (a < 64'h0B40_0000) return 1;
    if (a < 64'h10E0_0000) return 2;
    return 3;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_angle"}, angle_out, 0);
    check({tag, "_x0"}, x0_out, 0);
    check({tag, "_y0"}, y0_out, 0);
    check({tag, "_sv"}, sample_valid, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_idx"}, result_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // One sweep from start pulse to return to IDLE, with random ignored starts and
  // random or windowed hold; checks every cycle against the model.
  task automatic run_sweep(input longint s_ang, input longint s_step, input int num,
                           input int hold_pct, input int hold_from, input int hold_len,
                           input bit hold_on_start);
    res_t   q[$];
    res_t   r;
    int     k = 0;
    int     done_cyc = -1;
    int     budget;
    bit     finished = 0;
    bit     exp_sv;
    longint a;
    budget = 4 * num + LAT + 20;
    @(posedge clk); #1;
    start = 1'b1;
    start_angle = s_ang[M:0];
    step_angle = s_step[M:0];
    num_samples = num[15:0];
    hold = hold_on_start;
    amp = $urandom;
    #1;
    check("start_sv", sample_valid, 0);
    check("start_busy", busy, 0);
    if (num == 0) done_cyc = 1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = (done_cyc < 0 || c <= done_cyc) ? ($urandom_range(0, 3) == 0) : 1'b0;
      start_angle = $urandom;
      step_angle = $urandom;
      num_samples = $urandom;
      hold = ($urandom_range(0, 99) < hold_pct) || (c >= hold_from && c < hold_from + hold_len);
      amp = $urandom;
      #1;
      exp_sv = (k < num) && !hold;
      a = model_angle(s_ang, s_step, k);
      check("sv", sample_valid, exp_sv);
      if (k < num) check("angle", angle_out, a);
      check("x0", x0_out, exp_sv ? amp : 0);
      check("y0", y0_out, 0);
      if (exp_sv) begin
        r.due = c + LAT; r.idx = k; r.ang = a;
        q.push_back(r);
        k++;
      end
      if (q.size() > 0 && q[0].due == c) begin
        check("rv", result_valid, 1);
        check("ridx", result_idx, q[0].idx);
`ifdef CORDIC_SEQ_QUAD_TAG_EN
        check("rquad", result_quad, model_quad(q[0].ang));
`endif
        if (q[0].idx == num - 1) done_cyc = c + 1;
        void'(q.pop_front());
      end else begin
        check("rv", result_valid, 0);
      end
      check("done", done, (c == done_cyc));
      check("busy", busy, (done_cyc < 0 || c <= done_cyc));
      check("err", err, 0);
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        finished = 1;
        break;
      end
    end
    check("sweep_finished", finished, 1);
    start = 1'b0;
    hold = 1'b0;
    $display("sweep start=%0h step=%0h num=%0d issued=%0d done_cycle=%0d", s_ang, s_step, num, k, done_cyc);
  endtask

  task automatic run_err(input longint s_ang, input longint s_step);
    @(posedge clk); #1;
    start = 1'b1; start_angle = s_ang[M:0]; step_angle = s_step[M:0]; num_samples = 16'd5;
    #1;
    check("err_c0", err, 0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_sv", sample_valid, 0);
    @(posedge clk); #2;
    check("err_clear", err, 0);
    check("err_busy2", busy, 0);
    $display("error start=%0h step=%0h", s_ang, s_step);
  endtask

  initial begin
    longint rs, rt;
    rst = 1'b1; start = 1'b0; hold = 1'b0; amp = '0;
    start_angle = '0; step_angle = '0; num_samples = '0;
    @(posedge clk); @(posedge clk); #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Twelve samples at 30 degrees.
    run_sweep(64'h0, 64'h01E0_0000, 12, 0, 0, 0, 1'b0);
    // Wrap through 360 degrees.
    run_sweep(64'h15E0_0000, 64'h0140_0000, 3, 0, 0, 0, 1'b0);
    // Empty sweep.
    run_sweep(64'h0, 64'h01E0_0000, 0, 0, 0, 0, 1'b0);
    // Out-of-range configuration.
    run_err(64'h0, 64'h1680_0000);
    run_err(64'h1680_0000, 64'h10);
    // Three-cycle hold after sample 2, with hold asserted on the start cycle too.
    run_sweep(64'h0100_0000, 64'h0234_5678, 8, 0, 4, 3, 1'b1);

    // Reset in the middle of a sweep.
    @(posedge clk); #1;
    start = 1'b1; start_angle = '0; step_angle = 32'h01E0_0000; num_samples = 16'd10; hold = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check("rst_run_sv", sample_valid, 1);
      check("rst_run_angle", angle_out, model_angle(0, 64'h01E0_0000, c - 1));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #2;
      check("postrst_rv", result_valid, 0);
      check("postrst_busy", busy, 0);
    end
    $display("mid-sweep reset applied after sample 4");
    run_sweep(64'h0050_0000, 64'h0300_0000, 10, 0, 0, 0, 1'b0);

    // Randomized sweeps with random hold.
    for (int t = 0; t < 6; t++) begin
      rs = longint'($urandom) % A360;
      rt = longint'($urandom) % A360;
      run_sweep(rs, rt, $urandom_range(1, 20), 30, 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_angle_sequencer.md
CORDIC_ANGLE_SEQUENCER -- requirements
Module: cordic_angle_sequencer

Interface
REQ-001 SHALL have parameter N, default 31, meaning data width minus one for x/y samples.
REQ-002 SHALL have parameter M, default 31, meaning angle width minus one; angle format is unsigned 12.20 degrees, 360 deg = 0x168_00000.
REQ-003 SHALL have parameter LAT, default 18, meaning the downstream rotator latency in cycles from sample to result.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-007 start_angle  input  M+1  first angle of the sweep.
REQ-008 step_angle  input  M+1  per-sample angle increment.
REQ-009 num_samples  input  16  number of samples in the sweep.
REQ-010 amp  input  N+1  signed vector magnitude driven on x.
REQ-011 hold  input  1  stalls sample issue while high.
REQ-012 angle_out  output  M+1  angle presented to the rotator.
REQ-013 x0_out, y0_out  output  N+1 each  rotator input vector.
REQ-014 sample_valid  output  1  angle_out and x0_out/y0_out carry a live sample.
REQ-015 result_valid  output  1  rotator output for a sample is valid this cycle.
REQ-016 result_idx  output  16  index of the sample whose result is valid.
REQ-017 busy, done, err  output  1 each  status: busy is high outside IDLE; done and err are single-cycle pulses.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE with start=1: if start_angle >= 0x168_00000 or step_angle >= 0x168_00000, SHALL pulse err the next cycle and stay in IDLE.
REQ-020 IDLE with start=1 and num_samples=0 (valid angles) SHALL go to DONE with no sample_valid.
REQ-021 IDLE with start=1 and a valid config SHALL latch the config and enter RUN; the first sample_valid appears the next cycle with angle_out=start_angle.
REQ-022 RUN with hold=0 SHALL issue one sample per cycle; after each sample acc = acc+step, computed in M+2 bits and reduced by 0x168_00000 when the sum is >= 0x168_00000.
REQ-023 RUN with hold=1 SHALL drive sample_valid=0, keep angle_out and the sample count unchanged, and keep the delay line shifting.
REQ-024 x0_out SHALL equal amp and y0_out SHALL equal 0 while sample_valid=1; both SHALL be 0 otherwise.
REQ-025 After the num_samples-th sample, SHALL enter DRAIN.
REQ-026 A LAT-deep delay line SHALL carry {sample_valid, index}; result_valid/result_idx SHALL equal sample_valid/index from exactly LAT cycles earlier.
REQ-027 Indices SHALL start at 0 and be contiguous regardless of hold gaps.
REQ-028 DRAIN SHALL exit to DONE on the cycle the last result_valid is asserted; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-029 start outside IDLE SHALL be ignored; start and hold in the same IDLE cycle SHALL still start.

Reset
REQ-030 rst=1 SHALL force IDLE and clear the delay line, accumulator and counters; on the next edge every output SHALL be 0, including mid-sweep, with no stale result_valid afterwards.

Configuration
REQ-031 Macro CORDIC_SEQ_QUAD_TAG_EN defined: SHALL add output result_quad[1:0], delayed LAT cycles with result_valid, giving the issued angle quadrant (0: <90, 1: <180, 2: <270, 3: otherwise).
REQ-032 Macro undefined: the result_quad port and its delay storage SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 start_angle=0, step=0x01E_00000, num=12 -> angle_out 0,30..330 deg on 12 consecutive cycles; result_valid idx 0..11 starting LAT cycles later; done one cycle after idx 11.
REQ-034 start=0x15E_00000, step=0x014_00000, num=3 -> angle_out 0x15E_00000, 0x00A_00000, 0x01E_00000; with macro defined, result_quad 3,0,0.
REQ-035 num=0 -> no sample_valid or result_valid; done pulses; busy low afterwards.
REQ-036 step=0x168_00000 -> err single-cycle pulse; state stays IDLE; busy stays 0.
REQ-037 num=8 with hold=1 for 3 cycles after sample 2 -> 3-cycle gap with angle held; idx 0..7 contiguous; result gap mirrors the issue gap.
REQ-038 rst pulse at sample 4 of 10 -> all outputs 0 the next cycle; no result_valid in the following LAT cycles; a new start runs normally.
